decode_operand_stage: RTL

- Decode/operand-fetch stage between instruction fetch and the per-operand latch/execute stage.
- Accepts one 32-bit RV32I instruction per handshake, decodes fields and immediate, and reads rs1/rs2 from an internal 32x32 register file with write-back bypass.
- Presents registered operands to execute through a valid/ready handshake; stall and flush are supported.

---
 rtl/rv_decode_pkg.sv | 52 +++++
 rtl/regfile_2r1w.sv | 28 ++
 rtl/decode_operand_stage.sv | 112 +++++++++++
 3 files changed

// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode definitions: opcodes, instruction classes, immediate generation
// and the packet held between decode and execute.
package rv_decode_pkg;
  localparam int DXLEN = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {IT_R, IT_I, IT_S, IT_B, IT_U, IT_J, IT_ILL} itype_e;

  typedef struct packed {
    logic [DXLEN-1:0] pc;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [4:0]       rd;
    logic [DXLEN-1:0] rs1_data;
    logic [DXLEN-1:0] rs2_data;
    logic [DXLEN-1:0] imm;
    logic             illegal;
  } ex_pkt_t;

  function automatic itype_e dec_type(input logic [6:0] op);
    case (op)
      OP_R:                      return IT_R;
      OP_IMM, OP_LOAD, OP_JALR:  return IT_I;
      OP_STORE:                  return IT_S;
      OP_BRANCH:                 return IT_B;
      OP_LUI, OP_AUIPC:          return IT_U;
      OP_JAL:                    return IT_J;
      default:                   return IT_ILL;
    endcase
  endfunction

  function automatic logic [DXLEN-1:0] gen_imm(input logic [31:0] ins, input itype_e t);
    case (t)
      IT_I:    return {{20{ins[31]}}, ins[31:20]};
      IT_S:    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IT_B:    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IT_U:    return {ins[31:12], 12'b0};
      IT_J:    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction
endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational reads, one synchronous write, x0 tied to zero.
module regfile_2r1w #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);
  logic [XLEN-1:0] r_regs [NREGS];

  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                    r_regs[g] <= '0;
      else if (we && (g != 0) && waddr == AW'(g))  r_regs[g] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : r_regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : r_regs[raddr2];
endmodule

// File: rtl/decode_operand_stage.sv
// RV32I decode / operand-fetch stage: decodes one instruction per handshake, reads operands
// with write-back bypass, and holds a registered packet for execute.
module decode_operand_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN  = DXLEN,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct7,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic            ex_illegal
);
  itype_e          w_type;
  logic [4:0]      w_rs1_idx, w_rs2_idx;
  logic [XLEN-1:0] w_rf1, w_rf2;
  ex_pkt_t         w_pkt;
  logic            w_acc;

  logic            r_valid;
  ex_pkt_t         r_pkt;
  logic [4:0]      r_rs1, r_rs2;

  regfile_2r1w #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk(clk), .rst(rst),
    .we(wb_en), .waddr(wb_addr), .wdata(wb_data),
    .raddr1(w_rs1_idx), .raddr2(w_rs2_idx),
    .rdata1(w_rf1), .rdata2(w_rf2)
  );

  assign in_ready = !r_valid || ex_ready;
  assign w_acc    = in_valid && in_ready && !flush;

  // Gated operands get index 0, so they read zero and are never refreshed.
  always_comb begin
    w_type    = dec_type(in_instr[6:0]);
    w_rs1_idx = '0;
    w_rs2_idx = '0;
    case (w_type)
      IT_R, IT_S, IT_B: begin
        w_rs1_idx = in_instr[19:15];
        w_rs2_idx = in_instr[24:20];
      end
      IT_I:    w_rs1_idx = in_instr[19:15];
      default: ;
    endcase
  end

  always_comb begin
    w_pkt          = '0;
    w_pkt.pc       = in_pc;
    w_pkt.opcode   = in_instr[6:0];
    w_pkt.funct3   = in_instr[14:12];
    w_pkt.funct7   = in_instr[31:25];
    w_pkt.rd       = (w_type == IT_S || w_type == IT_B) ? 5'd0 : in_instr[11:7];
    w_pkt.rs1_data = (wb_en && wb_addr == w_rs1_idx && w_rs1_idx != '0) ? wb_data : w_rf1;
    w_pkt.rs2_data = (wb_en && wb_addr == w_rs2_idx && w_rs2_idx != '0) ? wb_data : w_rf2;
    w_pkt.imm      = gen_imm(in_instr, w_type);
    w_pkt.illegal  = (w_type == IT_ILL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_pkt   <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
    end else begin
      if (flush)         r_valid <= 1'b0;
      else if (w_acc)    r_valid <= 1'b1;
      else if (ex_ready) r_valid <= 1'b0;

      if (w_acc) begin
        r_pkt <= w_pkt;
        r_rs1 <= w_rs1_idx;
        r_rs2 <= w_rs2_idx;
      end else if (r_valid && !ex_ready) begin
        // Write-back landing while stalled keeps the held operands current.
        if (wb_en && wb_addr != '0 && wb_addr == r_rs1) r_pkt.rs1_data <= wb_data;
        if (wb_en && wb_addr != '0 && wb_addr == r_rs2) r_pkt.rs2_data <= wb_data;
      end
    end
  end

  assign ex_valid    = r_valid;
  assign ex_pc       = r_pkt.pc;
  assign ex_opcode   = r_pkt.opcode;
  assign ex_funct3   = r_pkt.funct3;
  assign ex_funct7   = r_pkt.funct7;
  assign ex_rd       = r_pkt.rd;
  assign ex_rs1_data = r_pkt.rs1_data;
  assign ex_rs2_data = r_pkt.rs2_data;
  assign ex_imm      = r_pkt.imm;
  assign ex_illegal  = r_pkt.illegal;
endmodule
